tx_frame_builder: RTL and testbench
===================================

Name: tx_frame_builder

Overview:
- Transmit-side PLCP frame serializer for the 802.11a chain; the mirror of the receiver's frame parser.
- On Start it emits the following as a 1-bit/clock stream that feeds the convolutional encoder / interleaver path:
  - 96-bit preamble pattern.
  - SIGNAL field: RATE, reserved, LENGTH, parity, tail.
  - DATA field: SERVICE, PSDU, tail, pad.
- PSDU bytes are pulled through a valid/ready handshake.
- DATA bits are scrambled in-block. Tail bits are forced to zero after scrambling.

Parameters:
- PREAMBLE_BITS, 96, number of preamble bits emitted.
- PREAMBLE_PATTERN, {12{8'hAA}}, preamble bits, sent MSB first.
- N_DBPS, 24, data bits per OFDM symbol; DATA field is padded to a multiple of this (6 Mbps).

Ports:
- Clock  in  1  single block clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle frame request; sampled only in IDLE.
- Rate  in  4  RATE field; bit 3 is sent first.
- Length  in  12  PSDU octet count; bit 11 is sent first.
- Seed  in  7  scrambler initial state [7:1]; must be nonzero.
- Data_in  in  8  PSDU byte; sent LSB first.
- Data_valid  in  1  Data_in holds a valid byte.
- Data_ready  out  1  byte accepted this cycle (valid && ready).
- Output  out  1  serial frame bit.
- Output_valid  out  1  Output is a frame bit this cycle.
- Busy  out  1  high from accepted Start until the last frame bit.
- Done  out  1  one-cycle pulse with the final frame bit.
- Error  out  1  one-cycle pulse when Start is rejected.

Behaviour:
- Reset values:
  - All outputs are 0; state = IDLE; all counters = 0.
  - Scrambler state = 7'h7F.
  - Reset mid-frame aborts the frame immediately, with no Done.
- Start in IDLE:
  - If Length==0 or Seed==0: pulse Error next cycle and stay in IDLE.
  - Otherwise latch Rate, Length and Seed, set Busy, and go to PREAMBLE.
  - Start outside IDLE is ignored.
- Latency: the first preamble bit appears with Output_valid=1 on the cycle after Start is accepted.
- FSM, one bit per cycle unless stalled:
  - IDLE.
  - PREAMBLE: PREAMBLE_BITS cycles, pattern MSB first.
  - SIG_RATE: 4 bits.
  - SIG_RSVD: 1 bit, value 0.
  - SIG_LEN: 12 bits.
  - SIG_PARITY: 1 bit = XOR of the 17 preceding SIGNAL bits (even parity).
  - SIG_TAIL: 6 zeros.
  - SERVICE: 16 zeros before scrambling.
  - PSDU: 8*Length bits.
  - DATA_TAIL: 6 bits.
  - PAD: Npad bits.
  - Back to IDLE.
- SIGNAL field is never scrambled.
- Scrambler:
  - Loaded from the latched Seed on entry to SERVICE.
  - Each DATA bit: fb = s7^s4; out = in^fb; state shifts {s6..s1, fb}.
  - Applies to SERVICE, PSDU, tail and pad bits.
  - In DATA_TAIL the scrambler still advances, but Output is forced to 0.
- Npad:
  - Npad = (N_DBPS - ((22 + 8*Length) mod N_DBPS)) mod N_DBPS.
  - Computed with a running mod-N_DBPS counter across the DATA field, not a divider.
  - PAD ends when the counter wraps to 0; Npad==0 skips PAD.
- PSDU handshake:
  - Data_ready=1 only when in PSDU, the internal byte shift register is empty, and Data_valid=1.
  - The accepted byte's bit 0 goes out the same cycle.
  - Remaining 7 bits go out on the following cycles.
  - Data_ready never asserts during bits 1..7.
  - Stall: if a byte is needed and Data_valid=0, Output_valid=0 and nothing advances (counters, scrambler).
- Done is coincident with the last PAD bit, or the last DATA_TAIL bit if Npad==0. Busy drops on the next cycle.
- Counter widths:
  - PSDU bit counter is 15 bits (max 8*4095).
  - Preamble counter is clog2(PREAMBLE_BITS).

Decomposition:
- Shared package `phy_pkg`:
  - State enumeration.
  - Field widths: RATE 4, LENGTH 12, SERVICE 16, TAIL 6.
  - Default preamble constant and N_DBPS defaults.
  - Scrambler polynomial taps (7,4).
  - These are shared with the receiver and descrambler.
- One natural sub-module: `frame_scrambler`.
  - Seed load, enable, serial in/out.
  - It is the transmit counterpart of the existing descrambler.

Test Plan:
1. Reset, then Start with Rate=4'b1101, Length=1, Seed=7'h5D, byte 8'h00 always valid:
   - Output_valid high for exactly 96+24+48 = 168 consecutive cycles; 18 pad bits.
   - First 96 bits are AA repeated.
   - SIGNAL = 1101 0 000000000001 parity=0 000000.
   - Done on cycle 168.
2. Seed=7'h7F with a Length=1 PSDU of all zeros:
   - DATA bits before tail equal the standard scrambler sequence 00001110 11110010 11001001 00000010 ….
   - The 6 tail bits read 0 despite a nonzero scrambler state.
3. Length=2, with Data_valid dropped for 5 cycles before the second byte:
   - Output_valid low for exactly those 5 cycles.
   - Total valid bits = 96+24+48.
   - The second byte's scrambled bits match the unstalled reference.
4. Length=0, or Seed=0:
   - Error pulses for 1 cycle; Busy, Output_valid and Data_ready stay 0.
   - A second Start issued mid-frame is ignored, with unchanged bit count.
5. Reset asserted at bit 150 of a Length=3 frame:
   - All outputs go to 0 immediately with no Done.
   - A new Start after release produces a correct full frame.
6. Length=1 with N_DBPS overridden to 30:
   - Npad=0 and PAD is skipped.
   - Done coincides with the last tail bit; 150 valid cycles total.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared 802.11a PHY definitions: frame-builder state encoding, PLCP field
// widths, preamble and symbol-size defaults, and the scrambler polynomial.
// The receive-side parser and the descrambler use the same definitions.
package phy_pkg;

    // Frame sections, in the order they go out on the serial stream.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SIG_RATE,
        ST_SIG_RSVD,
        ST_SIG_LEN,
        ST_SIG_PARITY,
        ST_SIG_TAIL,
        ST_SERVICE,
        ST_PSDU,
        ST_DATA_TAIL,
        ST_PAD
    } tx_state_e;

    localparam int RATE_W    = 4;
    localparam int LENGTH_W  = 12;
    localparam int SERVICE_W = 16;
    localparam int TAIL_W    = 6;
    localparam int SEED_W    = 7;

    localparam int          PREAMBLE_BITS_DEF    = 96;
    localparam logic [95:0] PREAMBLE_PATTERN_DEF = {12{8'hAA}};
    localparam int          N_DBPS_DEF           = 24;

    // Scrambler polynomial x^7 + x^4 + 1; taps are 1-based stage numbers.
    localparam int                SCR_TAP_A       = 7;
    localparam int                SCR_TAP_B       = 4;
    localparam logic [SEED_W-1:0] SCR_RESET_STATE = 7'h7F;

    // Feedback bit of the scrambler; state[6:0] holds stages s7..s1.
    function automatic logic scr_feedback(input logic [SEED_W-1:0] s);
        return s[SCR_TAP_A-1] ^ s[SCR_TAP_B-1];
    endfunction

endpackage

// File: rtl/tx_frame_builder_if.sv
// Frame request, PSDU byte handshake and serial output of the frame builder.
// The slave modport is the builder itself, the master modport is whatever
// issues the request, feeds the bytes and consumes the bit stream.
interface tx_frame_builder_if;
    import phy_pkg::*;

    logic                start;
    logic [RATE_W-1:0]   rate;
    logic [LENGTH_W-1:0] length;
    logic [SEED_W-1:0]   seed;
    logic [7:0]          data;
    logic                data_valid;
    logic                data_ready;
    logic                out_bit;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic                error;

    modport slave (
        input  start, rate, length, seed, data, data_valid,
        output data_ready, out_bit, out_valid, busy, done, error
    );

    modport master (
        output start, rate, length, seed, data, data_valid,
        input  data_ready, out_bit, out_valid, busy, done, error
    );
endinterface

// File: rtl/frame_scrambler.sv
// Serial x^7+x^4+1 frame scrambler, the transmit twin of the descrambler.
// The output is combinational in the current state; the state only moves
// on a load or an enabled bit.
module frame_scrambler
    import phy_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic              bit_o
);

    logic [SEED_W-1:0] state_q;
    logic [SEED_W-1:0] state_d;
    logic              fb;

    assign fb    = scr_feedback(state_q);
    assign bit_o = bit_i ^ fb;

    // Next state: seed load wins over an advance.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = {state_q[SEED_W-2:0], fb};
        end
    end

    // Scrambler state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SCR_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/tx_frame_builder.sv
// 802.11a PLCP transmit frame serializer: preamble, SIGNAL and scrambled
// DATA field sent one bit per clock, PSDU bytes pulled over valid/ready.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_IDLE       | waiting for Start; bad Length/Seed pulses Error
// ST_PREAMBLE   | preamble pattern, MSB first
// ST_SIG_RATE   | RATE, bit 3 first
// ST_SIG_RSVD   | reserved bit, 0
// ST_SIG_LEN    | LENGTH, bit 11 first
// ST_SIG_PARITY | even parity over the 17 preceding SIGNAL bits
// ST_SIG_TAIL   | six zeros; scrambler seeded on the last one
// ST_SERVICE    | sixteen scrambled zeros
// ST_PSDU       | PSDU bytes LSB first, stalls while no byte is offered
// ST_DATA_TAIL  | six zeros, scrambler advances but output forced low
// ST_PAD        | scrambled zeros up to the next N_DBPS boundary
module tx_frame_builder
    import phy_pkg::*;
#(
    parameter int                       PREAMBLE_BITS    = PREAMBLE_BITS_DEF,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = PREAMBLE_PATTERN_DEF,
    parameter int                       N_DBPS           = N_DBPS_DEF
)(
    input  logic              clk_i,
    input  logic              rst_i,
    tx_frame_builder_if.slave bus
);

    localparam int PRE_W = $clog2(PREAMBLE_BITS);
    localparam int MOD_W = $clog2(N_DBPS);

    tx_state_e             state_q, state_d;
    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [3:0]            fld_cnt_q, fld_cnt_d;
    logic [14:0]           psdu_cnt_q, psdu_cnt_d;
    logic [MOD_W-1:0]      mod_cnt_q, mod_cnt_d;
    logic [6:0]            sh_q, sh_d;
    logic [2:0]            sh_cnt_q, sh_cnt_d;
    logic                  par_q, par_d;
    logic [RATE_W-1:0]     rate_q, rate_d;
    logic [LENGTH_W-1:0]   len_q, len_d;
    logic [SEED_W-1:0]     seed_q, seed_d;
    logic                  error_q, error_d;

    logic             bit_raw;
    logic             out_valid;
    logic             data_ready;
    logic             done;
    logic             is_data;
    logic             force_zero;
    logic             scr_load;
    logic             scr_en;
    logic             scr_out;
    logic [MOD_W-1:0] mod_next;

    frame_scrambler u_scrambler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (scr_load),
        .seed_i (seed_q),
        .en_i   (scr_en),
        .bit_i  (bit_raw),
        .bit_o  (scr_out)
    );

    // Next-state, counters and per-cycle outputs of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        fld_cnt_d  = fld_cnt_q;
        psdu_cnt_d = psdu_cnt_q;
        mod_cnt_d  = mod_cnt_q;
        sh_d       = sh_q;
        sh_cnt_d   = sh_cnt_q;
        par_d      = par_q;
        rate_d     = rate_q;
        len_d      = len_q;
        seed_d     = seed_q;
        error_d    = 1'b0;
        bit_raw    = 1'b0;
        out_valid  = 1'b0;
        data_ready = 1'b0;
        done       = 1'b0;
        is_data    = 1'b0;
        force_zero = 1'b0;
        scr_load   = 1'b0;
        scr_en     = 1'b0;
        // Running DATA-field position modulo N_DBPS; wrap to 0 ends the frame.
        mod_next   = (mod_cnt_q == MOD_W'(N_DBPS - 1)) ? '0 : mod_cnt_q + MOD_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.length == '0) || (bus.seed == '0)) begin
                        error_d = 1'b1;
                    end else begin
                        rate_d    = bus.rate;
                        len_d     = bus.length;
                        seed_d    = bus.seed;
                        pre_cnt_d = PRE_W'(PREAMBLE_BITS - 1);
                        par_d     = 1'b0;
                        mod_cnt_d = '0;
                        sh_cnt_d  = '0;
                        state_d   = ST_PREAMBLE;
                    end
                end
            end

            ST_PREAMBLE: begin
                out_valid = 1'b1;
                bit_raw   = PREAMBLE_PATTERN[pre_cnt_q];
                if (pre_cnt_q == '0) begin
                    fld_cnt_d = 4'(RATE_W - 1);
                    state_d   = ST_SIG_RATE;
                end else begin
                    pre_cnt_d = pre_cnt_q - PRE_W'(1);
                end
            end

            ST_SIG_RATE: begin
                out_valid = 1'b1;
                bit_raw   = rate_q[fld_cnt_q[1:0]];
                par_d     = par_q ^ bit_raw;
                if (fld_cnt_q == '0) begin
                    state_d = ST_SIG_RSVD;
                end else begin
                    fld_cnt_d = fld_cnt_q - 4'd1;
                end
            end

            ST_SIG_RSVD: begin
                out_valid = 1'b1;
                fld_cnt_d = 4'(LENGTH_W - 1);
                state_d   = ST_SIG_LEN;
            end

            ST_SIG_LEN: begin
                out_valid = 1'b1;
                bit_raw   = len_q[fld_cnt_q];
                par_d     = par_q ^ bit_raw;
                if (fld_cnt_q == '0) begin
                    state_d = ST_SIG_PARITY;
                end else begin
                    fld_cnt_d = fld_cnt_q - 4'd1;
                end
            end

            ST_SIG_PARITY: begin
                out_valid = 1'b1;
                bit_raw   = par_q;
                fld_cnt_d = 4'(TAIL_W - 1);
                state_d   = ST_SIG_TAIL;
            end

            ST_SIG_TAIL: begin
                out_valid = 1'b1;
                if (fld_cnt_q == '0) begin
                    scr_load  = 1'b1;
                    fld_cnt_d = 4'(SERVICE_W - 1);
                    state_d   = ST_SERVICE;
                end else begin
                    fld_cnt_d = fld_cnt_q - 4'd1;
                end
            end

            ST_SERVICE: begin
                out_valid = 1'b1;
                is_data   = 1'b1;
                scr_en    = 1'b1;
                mod_cnt_d = mod_next;
                if (fld_cnt_q == '0) begin
                    psdu_cnt_d = {len_q, 3'b000} - 15'd1;
                    state_d    = ST_PSDU;
                end else begin
                    fld_cnt_d = fld_cnt_q - 4'd1;
                end
            end

            ST_PSDU: begin
                is_data = 1'b1;
                if (sh_cnt_q == '0) begin
                    // Shift register empty: take a fresh byte or stall.
                    if (bus.data_valid) begin
                        data_ready = 1'b1;
                        out_valid  = 1'b1;
                        bit_raw    = bus.data[0];
                        sh_d       = bus.data[7:1];
                        sh_cnt_d   = 3'd7;
                    end
                end else begin
                    out_valid = 1'b1;
                    bit_raw   = sh_q[0];
                    sh_d      = {1'b0, sh_q[6:1]};
                    sh_cnt_d  = sh_cnt_q - 3'd1;
                end
                if (out_valid) begin
                    scr_en    = 1'b1;
                    mod_cnt_d = mod_next;
                    if (psdu_cnt_q == '0) begin
                        fld_cnt_d = 4'(TAIL_W - 1);
                        state_d   = ST_DATA_TAIL;
                    end else begin
                        psdu_cnt_d = psdu_cnt_q - 15'd1;
                    end
                end
            end

            ST_DATA_TAIL: begin
                out_valid  = 1'b1;
                is_data    = 1'b1;
                force_zero = 1'b1;
                scr_en     = 1'b1;
                mod_cnt_d  = mod_next;
                if (fld_cnt_q == '0) begin
                    if (mod_next == '0) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    fld_cnt_d = fld_cnt_q - 4'd1;
                end
            end

            ST_PAD: begin
                out_valid = 1'b1;
                is_data   = 1'b1;
                scr_en    = 1'b1;
                mod_cnt_d = mod_next;
                if (mod_next == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            fld_cnt_q  <= '0;
            psdu_cnt_q <= '0;
            mod_cnt_q  <= '0;
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            par_q      <= 1'b0;
            rate_q     <= '0;
            len_q      <= '0;
            seed_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            fld_cnt_q  <= fld_cnt_d;
            psdu_cnt_q <= psdu_cnt_d;
            mod_cnt_q  <= mod_cnt_d;
            sh_q       <= sh_d;
            sh_cnt_q   <= sh_cnt_d;
            par_q      <= par_d;
            rate_q     <= rate_d;
            len_q      <= len_d;
            seed_q     <= seed_d;
            error_q    <= error_d;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_bit    = out_valid & (is_data ? (~force_zero & scr_out) : bit_raw);
    assign bus.data_ready = data_ready;
    assign bus.done       = done;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.error      = error_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: one instance at N_DBPS=24 and one at
// N_DBPS=30, each compared against hand values and a reference bit model.
module tb_tx_frame_builder;
    import phy_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_frame_builder_if if24 ();
    tx_frame_builder_if if30 ();

    logic        start;
    logic        sel30;
    logic [3:0]  rate;
    logic [11:0] len;
    logic [6:0]  seed;
    logic [7:0]  din;
    logic        dvalid;

    assign if24.start      = start & ~sel30;
    assign if30.start      = start & sel30;
    assign if24.rate       = rate;
    assign if30.rate       = rate;
    assign if24.length     = len;
    assign if30.length     = len;
    assign if24.seed       = seed;
    assign if30.seed       = seed;
    assign if24.data       = din;
    assign if30.data       = din;
    assign if24.data_valid = dvalid;
    assign if30.data_valid = dvalid;

    tx_frame_builder #(.N_DBPS(24)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if24)
    );

    tx_frame_builder #(.N_DBPS(30)) dut30 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if30)
    );

    wire o_bit   = sel30 ? if30.out_bit    : if24.out_bit;
    wire o_valid = sel30 ? if30.out_valid  : if24.out_valid;
    wire o_ready = sel30 ? if30.data_ready : if24.data_ready;
    wire o_busy  = sel30 ? if30.busy       : if24.busy;
    wire o_done  = sel30 ? if30.done       : if24.done;
    wire o_err   = sel30 ? if30.error      : if24.error;

    int   n_chk = 0;
    int   n_bad = 0;
    logic got_q[$];
    logic exp_q[$];
    logic [7:0] psdu [0:3];
    int   n_valid, n_low, done_cnt, done_idx, err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int s, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w = {w[30:0], (s + i < got_q.size()) ? got_q[s + i] : 1'b0};
        end
        return w;
    endfunction

    // Reference frame built straight from the field layout.
    task automatic build_exp(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd, input int ndbps);
        logic [95:0] pat;
        logic [6:0]  s;
        logic        par, fb, b;
        int          nb, npad, ndata;
        pat = {12{8'hAA}};
        exp_q.delete();
        for (int i = 95; i >= 0; i--) exp_q.push_back(pat[i]);
        par = 1'b0;
        for (int i = 3; i >= 0; i--) begin exp_q.push_back(r[i]); par ^= r[i]; end
        exp_q.push_back(1'b0);
        for (int i = 11; i >= 0; i--) begin exp_q.push_back(l[i]); par ^= l[i]; end
        exp_q.push_back(par);
        repeat (6) exp_q.push_back(1'b0);
        nb    = 8 * int'(l);
        npad  = (ndbps - ((22 + nb) % ndbps)) % ndbps;
        ndata = 16 + nb + 6 + npad;
        s     = sd;
        for (int k = 0; k < ndata; k++) begin
            b = 1'b0;
            if (k >= 16 && k < 16 + nb) b = psdu[(k - 16) / 8][(k - 16) % 8];
            fb = s[6] ^ s[3];
            s  = {s[5:0], fb};
            if (k >= 16 + nb && k < 22 + nb) exp_q.push_back(1'b0);
            else                              exp_q.push_back(b ^ fb);
        end
    endtask

    task automatic cmp_frame();
        int mism;
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        check("n_bits", got_q.size(), exp_q.size());
        check("bit_diff", mism, 0);
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd,
                             input int stall_at, input int stall_n, input int restart_at, input int abort_at);
        int  cyc, bidx, stall_rem;
        bit  fin, restarted, aborted;
        got_q.delete();
        n_valid = 0; n_low = 0; done_cnt = 0; done_idx = -1; err_cnt = 0;
        cyc = 0; bidx = 0; stall_rem = stall_n; fin = 0; restarted = 0; aborted = 0;
        @(negedge clk);
        rate = r; len = l; seed = sd; dvalid = 1'b1; din = psdu[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 1000) begin
            if (abort_at >= 0 && n_valid == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_outputs", {o_busy, o_valid, o_ready, o_done, o_err}, 5'b0);
                check("abort_no_done", done_cnt, 0);
                aborted = 1;
                fin = 1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                break;
            end
            dvalid = !(stall_rem > 0 && n_valid == stall_at);
            if (restart_at >= 0 && n_valid == restart_at && !restarted) begin
                start = 1'b1;
                len = 12'd3;
                restarted = 1;
            end
            din = psdu[bidx < 4 ? bidx : 3];
            #1;
            if (cyc == 0) check("first_bit", {o_valid, o_busy}, 2'b11);
            if (o_ready) bidx++;
            if (!dvalid) stall_rem--;
            if (o_valid) begin
                got_q.push_back(o_bit);
                n_valid++;
            end else begin
                n_low++;
            end
            if (o_err) err_cnt++;
            if (o_done) begin
                done_cnt++;
                done_idx = n_valid;
                fin = 1;
            end
            cyc++;
            @(negedge clk);
            start = 1'b0;
            dvalid = 1'b1;
        end
        if (!aborted) begin
            check("timeout", fin, 1'b1);
            #1;
            check("busy_drop", o_busy, 1'b0);
            check("done_count", done_cnt, 1);
        end
    endtask

    task automatic reject(input logic [11:0] l, input logic [6:0] sd);
        @(negedge clk);
        rate = 4'b1101; len = l; seed = sd; dvalid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_pulse", {o_err, o_busy, o_valid, o_ready}, 4'b1000);
        @(negedge clk);
        #1;
        check("err_clear", {o_err, o_busy, o_valid, o_ready}, 4'b0000);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel30 = 1'b0; rate = '0; len = '0; seed = '0;
        din = '0; dvalid = 1'b0;
        psdu[0] = 8'h00; psdu[1] = 8'h00; psdu[2] = 8'h00; psdu[3] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {if24.busy, if24.out_valid, if24.data_ready, if24.done, if24.error,
                                if30.busy, if30.out_valid}, 7'b0);
        @(negedge clk);
        rst = 1'b0;

        // Length 1, Seed 5D: framing, preamble, SIGNAL, pad length.
        build_exp(4'b1101, 12'd1, 7'h5D, 24);
        run_frame(4'b1101, 12'd1, 7'h5D, -1, 0, -1, -1);
        cmp_frame();
        check("t1_done_idx", done_idx, 168);
        check("t1_no_gap", n_low, 0);
        check("t1_pre0", word(0, 32), 32'hAAAAAAAA);
        check("t1_pre1", word(32, 32), 32'hAAAAAAAA);
        check("t1_pre2", word(64, 32), 32'hAAAAAAAA);
        check("t1_signal", word(96, 24), 32'(24'b1101_0_000000000001_0_000000));

        // Seed 7F, zero PSDU: raw scrambler sequence, zeroed tail.
        build_exp(4'b1101, 12'd1, 7'h7F, 24);
        run_frame(4'b1101, 12'd1, 7'h7F, -1, 0, -1, -1);
        cmp_frame();
        check("t2_scr_seq", word(120, 24), 32'(24'b00001110_11110010_11001001));
        check("t2_tail", word(144, 6), 32'h0);

        // Length 2 with a 5-cycle gap before the second byte.
        psdu[0] = 8'hA5; psdu[1] = 8'h3C;
        build_exp(4'b1011, 12'd2, 7'h2B, 24);
        run_frame(4'b1011, 12'd2, 7'h2B, 144, 5, -1, -1);
        cmp_frame();
        check("t3_gap", n_low, 5);
        check("t3_done_idx", done_idx, 168);

        // Rejected requests, then an ignored mid-frame Start.
        reject(12'd0, 7'h5D);
        reject(12'd1, 7'h00);
        psdu[0] = 8'h00;
        build_exp(4'b1101, 12'd1, 7'h5D, 24);
        run_frame(4'b1101, 12'd1, 7'h5D, -1, 0, 50, -1);
        cmp_frame();
        check("t4_no_err", err_cnt, 0);
        check("t4_done_idx", done_idx, 168);

        // Reset at bit 150 of a Length 3 frame, then a clean frame.
        psdu[0] = 8'h11; psdu[1] = 8'h22; psdu[2] = 8'h33;
        run_frame(4'b0101, 12'd3, 7'h41, -1, 0, -1, 150);
        check("t5_bits_at_abort", n_valid, 150);
        build_exp(4'b0101, 12'd3, 7'h41, 24);
        run_frame(4'b0101, 12'd3, 7'h41, -1, 0, -1, -1);
        cmp_frame();
        check("t5_done_idx", done_idx, 168);

        // N_DBPS 30: no pad, Done on the last tail bit.
        sel30 = 1'b1;
        psdu[0] = 8'h96;
        build_exp(4'b1101, 12'd1, 7'h5D, 30);
        run_frame(4'b1101, 12'd1, 7'h5D, -1, 0, -1, -1);
        cmp_frame();
        check("t6_done_idx", done_idx, 150);
        check("t6_tail", word(144, 6), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
